// File: rtl/reimu_shot_scheduler.sv
// Player shot scheduler: cooldown-limited round-robin launch into four bullet slots, plus round-robin hit arbitration.
// Latency: launch one cycle after the deciding edge; hit ack/damage one cycle after the sampled request.
// Backpressure: no launch while every slot is busy; hit requests are held by the slots until acked, one ack per cycle.
module reimu_shot_scheduler #(
  parameter int COOLDOWN = 8
) (
  input  logic        clk_22,
  input  logic        rst,
  input  logic        shoot,
  input  logic        reimuE,
  input  logic [9:0]  reimux,
  input  logic [9:0]  reimuy,
  input  logic [3:0]  slot_busy,
  input  logic [3:0]  hit_req,
  input  logic [11:0] hit_tgt,
  output logic [3:0]  launch,
  output logic [9:0]  launch_x,
  output logic [9:0]  launch_y,
  output logic [3:0]  hit_ack,
  output logic        dmg_valid,
  output logic [2:0]  dmg_tgt,
  output logic [15:0] shots_fired
);

  // Cooldown counter is just wide enough to hold COOLDOWN-1 (at least one bit).
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    READY    = 2'd1,
    COOL     = 2'd2
  } fire_state_t;

  fire_state_t    state;
  logic [CW-1:0]  cnt;
  logic [1:0]     lp;
  logic [1:0]     hp;

  logic [3:0]     free_mask;
  logic [1:0]     launch_pick;
  logic [3:0]     hit_mask;
  logic [1:0]     hit_pick;
  logic [2:0]     hit_code;

  // Round-robin search: first set bit of req starting at ptr and wrapping.
  // Scanning the farthest offset first lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Candidate slot for a launch and candidate requester for a hit grant.
  // A slot acked this cycle is masked so its still-held request is not granted twice.
  always_comb begin
    free_mask   = ~slot_busy;
    launch_pick = rr_pick(free_mask, lp);
    hit_mask    = hit_req & ~hit_ack;
    hit_pick    = rr_pick(hit_mask, hp);
    case (hit_pick)
      2'd0:    hit_code = hit_tgt[2:0];
      2'd1:    hit_code = hit_tgt[5:3];
      2'd2:    hit_code = hit_tgt[8:6];
      default: hit_code = hit_tgt[11:9];
    endcase
  end

  // Fire FSM: enable tracking, cooldown, round-robin launch and shot counting.
  always_ff @(posedge clk_22) begin
    if (rst) begin
      state       <= DISABLED;
      cnt         <= '0;
      lp          <= 2'd0;
      launch      <= 4'd0;
      launch_x    <= 10'd0;
      launch_y    <= 10'd0;
      shots_fired <= 16'd0;
    end else begin
      launch <= 4'd0;
      if (!reimuE) begin
        // Losing the player abandons any cooldown in progress.
        state <= DISABLED;
        cnt   <= '0;
      end else begin
        case (state)
          DISABLED: begin
            state <= READY;
          end
          READY: begin
            if (shoot && (slot_busy != 4'hF)) begin
              launch   <= 4'b0001 << launch_pick;
              launch_x <= reimux;
              launch_y <= reimuy;
              lp       <= launch_pick + 2'd1;
              if (shots_fired != 16'hFFFF) shots_fired <= shots_fired + 16'd1;
              state    <= COOL;
              cnt      <= CNT_LOAD;
            end
          end
          COOL: begin
            if (cnt == '0) state <= READY;
            else           cnt   <= cnt - CNT_ONE;
          end
          default: begin
            state <= DISABLED;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Hit arbiter: one grant per cycle, independent of the fire FSM.
  // Invalid target codes are acked to free the slot but raise no damage; dmg_tgt keeps its last value.
  always_ff @(posedge clk_22) begin
    if (rst) begin
      hp        <= 2'd0;
      hit_ack   <= 4'd0;
      dmg_valid <= 1'b0;
      dmg_tgt   <= 3'd0;
    end else if (hit_mask != 4'd0) begin
      hit_ack <= 4'b0001 << hit_pick;
      hp      <= hit_pick + 2'd1;
      if (hit_code <= 3'd4) begin
        dmg_valid <= 1'b1;
        dmg_tgt   <= hit_code;
      end else begin
        dmg_valid <= 1'b0;
      end
    end else begin
      hit_ack   <= 4'd0;
      dmg_valid <= 1'b0;
    end
  end

endmodule

// File: doc/reimu_shot_scheduler.md
# reimu_shot_scheduler

Schedules player shots and serializes bullet hits for the four-slot player bullet pool. On `shoot`, it rate-limits firing with a cooldown FSM and launches the next free slot, chosen round-robin. Hit reports from the slots are arbitrated into one damage event per cycle, which the HP bookkeeping logic (boss and enm1–4) consumes. It sits between the input/player logic and the per-slot bullet movers.

## Interface
- `COOLDOWN`, default 8 — cooldown count after a launch; legal range ≥1.
- `clk_22` in 1 — game clock; every register updates on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `shoot` in 1 — fire button, level-sensitive.
- `reimuE` in 1 — player alive/enabled.
- `reimux`, `reimuy` in 10 — player position, the spawn point for launched bullets.
- `slot_busy` in 4 — bit i is high while slot i has a bullet in flight.
- `hit_req` in 4 — bit i: slot i reports a hit and holds the request until acknowledged.
- `hit_tgt` in 12 — target code of slot i in bits [3i+2:3i]: 0 = boss, 1–4 = enm1–4, 5–7 = invalid.
- `launch` out 4 — one-hot, one-cycle pulse that starts slot i.
- `launch_x`, `launch_y` out 10 — spawn position, valid while `launch` ≠ 0.
- `hit_ack` out 4 — one-hot, one-cycle acknowledge to slot i.
- `dmg_valid` out 1 — one-cycle damage event.
- `dmg_tgt` out 3 — target of the damage event, valid while `dmg_valid`=1.
- `shots_fired` out 16 — saturating count of launches.

## Operation
- Fire FSM has three states: DISABLED, READY, COOL. A down-counter `cnt` has width ⌈log2(COOLDOWN)⌉, minimum 1 bit.
- Reset state and outputs: FSM = DISABLED, `cnt`=0, launch pointer `lp`=0, hit pointer `hp`=0. `launch`, `hit_ack`, `dmg_valid` = 0; `launch_x`, `launch_y`, `dmg_tgt`, `shots_fired` = 0.
- DISABLED → READY when `reimuE`=1. Every state goes to DISABLED when `reimuE`=0, which also clears `cnt`. No launch is issued in DISABLED.
- READY, `shoot`=1, at least one `slot_busy` bit = 0:
  - Pick the first free slot scanning `lp`, `lp`+1, … mod 4.
  - Next cycle: `launch` = one-hot of that slot; `launch_x`/`launch_y` = the `reimux`/`reimuy` sampled at the decision edge.
  - `lp` ← picked slot + 1 (mod 4); `shots_fired`++ (holds at 65535).
  - FSM → COOL with `cnt` = COOLDOWN−1.
- READY with all slots busy, or `shoot`=0: stay in READY, no launch, `lp` unchanged.
- COOL: if `cnt`=0 → READY, else `cnt`−−. `shoot` is ignored in COOL.
- Hit arbiter runs independently of the fire FSM, including in DISABLED:
  - Each cycle with `hit_req` ≠ 0, grant the first requester scanning `hp`, `hp`+1, … mod 4.
  - Next cycle: `hit_ack` = one-hot of the granted slot; `hp` ← granted + 1.
  - Valid target code: `dmg_valid`=1 and `dmg_tgt` = code, in the same cycle as `hit_ack`.
  - Invalid code (5–7): the request is still acked, `dmg_valid`=0, `dmg_tgt` holds its previous value.
- A slot with `hit_ack` high this cycle is excluded from arbitration this cycle, so a held request that was just acked is never double-granted.
- `launch` and `hit_ack` for the same slot may be asserted in the same cycle; the two are independent.

## Timing
- Launch latency: 1 cycle from the edge that samples `shoot`=1 in READY.
- With `shoot` held and slots free, the launch period is COOLDOWN+1 cycles. For COOLDOWN=8: launches at cycles c, c+9, c+18, …
- Hit latency: 1 cycle from the sampled `hit_req` to `hit_ack`/`dmg_valid`. Throughput is one hit per cycle.
- `rst` mid-operation takes effect at the next edge: all outputs return to reset values and any pending launch or ack is dropped. A slot whose request was dropped this way re-requests and is served after reset.
- `reimuE` falling in COOL → DISABLED next cycle. On re-enable, the FSM enters READY and the first launch lands 2 cycles after `reimuE` rises, with no residual cooldown.
- All slots busy during a READY `shoot` → no launch. The launch is issued 1 cycle after a slot frees, if `shoot` is still held.

## Test plan
- Reset, then `reimuE`=1, `shoot` held, `slot_busy`=0, COOLDOWN=8 → `launch` = 0001, 0010, 0100, 1000, 0001 at cycles c, c+9, c+18, c+27, c+36. `launch_x`/`launch_y` equal the sampled player position; `shots_fired` reaches 5.
- `slot_busy`=1011, `lp`=0, shoot → `launch`=0100, then `lp`=3. Next shot with 1111 → no launch until a slot frees; bit 3 clears → `launch`=1000 one cycle later.
- `hit_req`=1111 held until ack, targets {0,2,7,4}, `hp`=0 → ack order 0001, 0010, 0100, 1000 on consecutive cycles. `dmg_valid` is 1, 1, 0, 1 and `dmg_tgt` = 0, 2, –, 4.
- `reimuE` dropped in COOL with `cnt`=5 → no launch while low. On re-enable with `shoot` held → launch 2 cycles later.
- `rst` asserted one cycle after a launch decision and with `hit_req`≠0 → next cycle all outputs are 0, the FSM is DISABLED, and the pointers are 0.
- `shots_fired` preloaded via a long run at 65535 → a further launch still pulses `launch`; the count stays at 65535.
